// File: rtl/cu_fsm.sv
// Multicycle control unit: FETCH/EXEC (+WRITEBACK for loads), with an INTR state for interrupt entry.
// Latency: 2 cycles per instruction, 3 for loads, +1 for interrupt entry. There is no backpressure, because the unit advances every cycle.
module cu_fsm (
    input  logic       CLK,
    input  logic       RST,
    input  logic [6:0] OPCODE,
    input  logic [2:0] FUNCT3,
    input  logic       INTR,
    input  logic       CSR_MIE,
    output logic       PCWrite,
    output logic       regWrite,
    output logic       memWE2,
    output logic       memRDEN1,
    output logic       memRDEN2,
    output logic       reset,
    output logic       csr_WE,
    output logic       int_taken,
    output logic       mret_exec,
    output logic [2:0] STATE
);

    localparam logic [2:0] ST_INIT  = 3'd0;
    localparam logic [2:0] ST_FETCH = 3'd1;
    localparam logic [2:0] ST_EXEC  = 3'd2;
    localparam logic [2:0] ST_WB    = 3'd3;
    localparam logic [2:0] ST_INTR  = 3'd4;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_REG    = 7'b0110011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;

    logic [2:0] state_q;
    logic [2:0] state_nxt;
    logic       irq_pending;

    assign irq_pending = INTR & CSR_MIE;
    assign STATE       = state_q;

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= ST_INIT;
        end else begin
            state_q <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = ST_INIT;
        case (state_q)
            ST_INIT:  state_nxt = ST_FETCH;
            ST_FETCH: state_nxt = ST_EXEC;
            ST_EXEC: begin
                // Loads always complete their writeback before an interrupt may be taken.
                if (OPCODE == OP_LOAD) begin
                    state_nxt = ST_WB;
                end else begin
                    state_nxt = irq_pending ? ST_INTR : ST_FETCH;
                end
            end
            ST_WB:    state_nxt = irq_pending ? ST_INTR : ST_FETCH;
            ST_INTR:  state_nxt = ST_FETCH;
            default:  state_nxt = ST_INIT;
        endcase
    end

    always_comb begin
        PCWrite   = 1'b0;
        regWrite  = 1'b0;
        memWE2    = 1'b0;
        memRDEN1  = 1'b0;
        memRDEN2  = 1'b0;
        reset     = 1'b0;
        csr_WE    = 1'b0;
        int_taken = 1'b0;
        mret_exec = 1'b0;
        case (state_q)
            ST_INIT:  reset    = 1'b1;
            ST_FETCH: memRDEN1 = 1'b1;
            ST_EXEC: begin
                case (OPCODE)
                    OP_LOAD: memRDEN2 = 1'b1;
                    OP_STORE: begin
                        memWE2  = 1'b1;
                        PCWrite = 1'b1;
                    end
                    OP_IMM, OP_REG, OP_LUI, OP_AUIPC, OP_JAL, OP_JALR: begin
                        PCWrite  = 1'b1;
                        regWrite = 1'b1;
                    end
                    OP_SYSTEM: begin
                        PCWrite = 1'b1;
                        case (FUNCT3)
                            3'b001, 3'b010, 3'b011: begin
                                regWrite = 1'b1;
                                csr_WE   = 1'b1;
                            end
                            3'b000:  mret_exec = 1'b1;
                            default: ;
                        endcase
                    end
                    // Branches and unrecognised opcodes only advance the PC.
                    default: PCWrite = 1'b1;
                endcase
            end
            ST_WB: begin
                regWrite = 1'b1;
                PCWrite  = 1'b1;
            end
            ST_INTR: begin
                int_taken = 1'b1;
                PCWrite   = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_cu_fsm.sv
// Directed bench for cu_fsm: checks state sequence and output enables against hand-computed values.
module tb_cu_fsm;

    logic       CLK = 1'b0;
    logic       RST = 1'b1;
    logic [6:0] OPCODE = 7'b0110011;
    logic [2:0] FUNCT3 = 3'b000;
    logic       INTR = 1'b0;
    logic       CSR_MIE = 1'b0;
    logic       PCWrite, regWrite, memWE2, memRDEN1, memRDEN2;
    logic       reset, csr_WE, int_taken, mret_exec;
    logic [2:0] STATE;

    int checks = 0;
    int passes = 0;

    // Output vector order: PCWrite regWrite memWE2 memRDEN1 memRDEN2 reset csr_WE int_taken mret_exec
    localparam logic [8:0] O_PCW  = 9'b100000000;
    localparam logic [8:0] O_RW   = 9'b010000000;
    localparam logic [8:0] O_WE2  = 9'b001000000;
    localparam logic [8:0] O_RD1  = 9'b000100000;
    localparam logic [8:0] O_RD2  = 9'b000010000;
    localparam logic [8:0] O_RST  = 9'b000001000;
    localparam logic [8:0] O_CSRW = 9'b000000100;
    localparam logic [8:0] O_INT  = 9'b000000010;
    localparam logic [8:0] O_MRET = 9'b000000001;

    logic [8:0] outs;
    assign outs = {PCWrite, regWrite, memWE2, memRDEN1, memRDEN2, reset, csr_WE, int_taken, mret_exec};

    logic [6:0] op_tab [0:9] = '{7'b0010011, 7'b0110011, 7'b0110111, 7'b0010111, 7'b1101111,
                                 7'b1100111, 7'b1100011, 7'b0000000, 7'b0001111, 7'b0100011};
    logic [8:0] ex_tab [0:9] = '{9'b110000000, 9'b110000000, 9'b110000000, 9'b110000000, 9'b110000000,
                                 9'b110000000, 9'b100000000, 9'b100000000, 9'b100000000, 9'b101000000};

    cu_fsm dut (
        .CLK(CLK), .RST(RST), .OPCODE(OPCODE), .FUNCT3(FUNCT3), .INTR(INTR), .CSR_MIE(CSR_MIE),
        .PCWrite(PCWrite), .regWrite(regWrite), .memWE2(memWE2), .memRDEN1(memRDEN1),
        .memRDEN2(memRDEN2), .reset(reset), .csr_WE(csr_WE), .int_taken(int_taken),
        .mret_exec(mret_exec), .STATE(STATE)
    );

    always #5 CLK = ~CLK;

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [2:0] exp_st, input logic [8:0] exp_o);
        checks++;
        assert (STATE === exp_st) passes++;
        else $error("FAIL %s STATE got %0d want %0d", tag, STATE, exp_st);
        checks++;
        assert (outs === exp_o) passes++;
        else $error("FAIL %s outputs got %b want %b", tag, outs, exp_o);
        checks++;
        assert (!(memWE2 && memRDEN2) && !(regWrite && memWE2)) passes++;
        else $error("FAIL %s exclusive enables got %b want no overlap", tag, outs);
    endtask

    initial begin
        // Reset, then an OP instruction.
        tick(); chk("rst", 3'd0, O_RST);
        tick(); chk("rst_hold", 3'd0, O_RST);
        RST = 1'b0;
        tick(); chk("op_fetch", 3'd1, O_RD1);
        tick(); chk("op_exec", 3'd2, O_PCW | O_RW);
        tick(); chk("op_next", 3'd1, O_RD1);

        // Load without interrupt.
        OPCODE = 7'b0000011;
        tick(); chk("ld_exec", 3'd2, O_RD2);
        tick(); chk("ld_wb", 3'd3, O_RW | O_PCW);
        tick(); chk("ld_next", 3'd1, O_RD1);

        // Store with interrupt pending and enabled; INTR stays high through the INTR state.
        OPCODE = 7'b0100011; INTR = 1'b1; CSR_MIE = 1'b1;
        tick(); chk("st_exec", 3'd2, O_WE2 | O_PCW);
        tick(); chk("st_intr", 3'd4, O_INT | O_PCW);
        tick(); chk("st_after_intr", 3'd1, O_RD1);

        // Load with interrupt held: taken only from WRITEBACK.
        OPCODE = 7'b0000011;
        tick(); chk("ldi_exec", 3'd2, O_RD2);
        tick(); chk("ldi_wb", 3'd3, O_RW | O_PCW);
        tick(); chk("ldi_intr", 3'd4, O_INT | O_PCW);
        INTR = 1'b0;
        tick(); chk("ldi_fetch", 3'd1, O_RD1);

        // Interrupt masked over ten instructions of mixed opcodes.
        INTR = 1'b1; CSR_MIE = 1'b0;
        for (int i = 0; i < 10; i++) begin
            OPCODE = op_tab[i];
            tick(); chk($sformatf("masked_exec%0d", i), 3'd2, ex_tab[i]);
            tick(); chk($sformatf("masked_fetch%0d", i), 3'd1, O_RD1);
        end
        INTR = 1'b0;

        // SYSTEM instructions.
        OPCODE = 7'b1110011; FUNCT3 = 3'b001;
        tick(); chk("csrrw", 3'd2, O_PCW | O_RW | O_CSRW);
        tick(); chk("csrrw_next", 3'd1, O_RD1);
        FUNCT3 = 3'b011;
        tick(); chk("csrrc", 3'd2, O_PCW | O_RW | O_CSRW);
        tick(); chk("csrrc_next", 3'd1, O_RD1);
        FUNCT3 = 3'b100;
        tick(); chk("sys_other", 3'd2, O_PCW);
        tick(); chk("sys_other_next", 3'd1, O_RD1);
        FUNCT3 = 3'b000; INTR = 1'b1; CSR_MIE = 1'b1;
        tick(); chk("mret", 3'd2, O_PCW | O_MRET);
        tick(); chk("mret_intr", 3'd4, O_INT | O_PCW);
        INTR = 1'b0;
        tick(); chk("mret_fetch", 3'd1, O_RD1);

        // Reset during WRITEBACK aborts the load.
        OPCODE = 7'b0000011;
        tick(); chk("rwb_exec", 3'd2, O_RD2);
        tick(); chk("rwb_wb", 3'd3, O_RW | O_PCW);
        RST = 1'b1;
        tick(); chk("rwb_rst", 3'd0, O_RST);
        RST = 1'b0;
        tick(); chk("rwb_fetch", 3'd1, O_RD1);

        // Reset during load EXEC.
        tick(); chk("rex_exec", 3'd2, O_RD2);
        RST = 1'b1;
        tick(); chk("rex_rst", 3'd0, O_RST);
        RST = 1'b0;
        tick(); chk("rex_fetch", 3'd1, O_RD1);

        // Reset while in INTR.
        OPCODE = 7'b0110011; INTR = 1'b1;
        tick(); chk("rin_exec", 3'd2, O_PCW | O_RW);
        tick(); chk("rin_intr", 3'd4, O_INT | O_PCW);
        RST = 1'b1;
        tick(); chk("rin_rst", 3'd0, O_RST);
        RST = 1'b0; INTR = 1'b0;
        tick(); chk("rin_fetch", 3'd1, O_RD1);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
